tx_sched: RTL and testbench

Packet-transmit scheduler between the command executor and the UART packet transmitter. Shares the single transmitter between two sources: solicited command responses and unsolicited interrupt-event packets built from the interrupt status word. Buffers one response, arbitrates round-robin, and sequences the transmitter `tx_busy` handshake. Rate-limits event packets with a holdoff timer.

---
 rtl/cmd_pkg.sv | 44 ++++
 rtl/tx_holdoff_timer.sv | 34 +++
 rtl/tx_sched.sv | 157 +++++++++++++++
 tb/tb_tx_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and helpers for the command/transmit path: scheduler states, grant encoding,
// packet type bytes and payload shaping used when a response is buffered.
package cmd_pkg;

    localparam int         MAX_PAYLOAD = 16;
    localparam int         EVT_LEN     = 5;
    localparam logic [7:0] PKT_OK      = 8'h81;
    localparam logic [7:0] PKT_EVT     = 8'h82;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACC  = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_t;

    typedef enum logic {
        GNT_RESP = 1'b0,
        GNT_EVT  = 1'b1
    } grant_t;

    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        if (len == 8'd0) begin
            return 8'd1;
        end
        if (len > 8'(MAX_PAYLOAD)) begin
            return 8'(MAX_PAYLOAD);
        end
        return len;
    endfunction

    // Bytes at or beyond len are forced to zero so tx_buf never leaks stale payload.
    function automatic logic [127:0] mask_payload(input logic [127:0] data, input logic [7:0] len);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (8'(k) < len) begin
                m[8*k +: 8] = data[8*k +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_holdoff_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement, zero is combinational
// from the count. No backpressure: it counts every cycle.
module tx_holdoff_timer #(
    parameter int HOLDOFF = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);
    localparam int W = $clog2(HOLDOFF + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(HOLDOFF);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_sched.sv
// Shares the UART transmitter between one buffered response and rate-limited interrupt events.
// Response handshake to tx_packet_wr is 2 cycles; resp_ready drops while the single entry is full, and nothing issues while tx_busy is high.
import cmd_pkg::*;

module tx_sched #(
    parameter int HOLDOFF   = 1000,
    parameter int ACCEPT_TO = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         resp_valid,
    output logic         resp_ready,
    input  logic [7:0]   resp_len,
    input  logic [127:0] resp_data,
    input  logic [31:0]  int_status,
    input  logic         evt_enable,
    input  logic         tx_busy,
    output logic         tx_packet_wr,
    output logic [7:0]   tx_payload_len,
    output logic [127:0] tx_buf,
    output logic         evt_sent,
    output logic         sched_busy
);
    localparam int AW = $clog2(ACCEPT_TO + 1);

    sched_state_t  state_q, state_d;
    grant_t        gnt_q, gnt_d, last_gnt_q, last_gnt_d, pick;
    logic          resp_full_q, resp_full_d;
    logic [7:0]    resp_len_q, resp_len_d;
    logic [127:0]  resp_dat_q, resp_dat_d;
    logic [7:0]    tx_len_q, tx_len_d;
    logic [127:0]  tx_buf_q, tx_buf_d;
    logic [AW-1:0] acc_cnt_q, acc_cnt_d;
    logic          resp_hs, resp_clr, evt_pend, holdoff_zero, holdoff_load;

    tx_holdoff_timer #(.HOLDOFF(HOLDOFF)) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .load (holdoff_load),
        .zero (holdoff_zero)
    );

    assign resp_ready     = !resp_full_q;
    assign resp_hs        = resp_valid && resp_ready;
    assign evt_pend       = evt_enable && (int_status != '0) && holdoff_zero;
    assign sched_busy     = (state_q != S_IDLE);
    assign tx_payload_len = tx_len_q;
    assign tx_buf         = tx_buf_q;

    // On a tie the source that did not win last time goes next.
    always_comb begin
        pick = GNT_EVT;
        if (resp_full_q && evt_pend) begin
            pick = (last_gnt_q == GNT_EVT) ? GNT_RESP : GNT_EVT;
        end else if (resp_full_q) begin
            pick = GNT_RESP;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_gnt_d   = last_gnt_q;
        tx_len_d     = tx_len_q;
        tx_buf_d     = tx_buf_q;
        acc_cnt_d    = acc_cnt_q;
        tx_packet_wr = 1'b0;
        evt_sent     = 1'b0;
        holdoff_load = 1'b0;
        resp_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && (resp_full_q || evt_pend)) begin
                    gnt_d = pick;
                    if (pick == GNT_RESP) begin
                        tx_len_d = resp_len_q;
                        tx_buf_d = resp_dat_q;
                    end else begin
                        tx_len_d = 8'(EVT_LEN);
                        tx_buf_d = {88'h0, int_status, PKT_EVT};
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An event whose status cleared since IDLE is dropped without a strobe.
                if (gnt_q == GNT_EVT && int_status == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tx_packet_wr = 1'b1;
                    last_gnt_d   = gnt_q;
                    acc_cnt_d    = '0;
                    state_d      = S_WAIT_ACC;
                    if (gnt_q == GNT_RESP) begin
                        resp_clr = 1'b1;
                    end else begin
                        evt_sent     = 1'b1;
                        holdoff_load = 1'b1;
                    end
                end
            end
            S_WAIT_ACC: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (acc_cnt_q == AW'(ACCEPT_TO - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    acc_cnt_d = acc_cnt_q + AW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        resp_full_d = resp_full_q;
        resp_len_d  = resp_len_q;
        resp_dat_d  = resp_dat_q;
        if (resp_hs) begin
            resp_full_d = 1'b1;
            resp_len_d  = clamp_len(resp_len);
            resp_dat_d  = mask_payload(resp_data, clamp_len(resp_len));
        end else if (resp_clr) begin
            resp_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= GNT_RESP;
            last_gnt_q  <= GNT_EVT;
            resp_full_q <= 1'b0;
            resp_len_q  <= '0;
            resp_dat_q  <= '0;
            tx_len_q    <= '0;
            tx_buf_q    <= '0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            resp_full_q <= resp_full_d;
            resp_len_q  <= resp_len_d;
            resp_dat_q  <= resp_dat_d;
            tx_len_q    <= tx_len_d;
            tx_buf_q    <= tx_buf_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: randomized responses and events checked against a byte-level packet model.
module tb_tx_sched;
    localparam int HOLDOFF   = 1000;
    localparam int ACCEPT_TO = 4;
    localparam int NB        = 8;

    logic         clk;
    logic         rst;
    logic         resp_valid;
    logic         resp_ready;
    logic [7:0]   resp_len;
    logic [127:0] resp_data;
    logic [31:0]  int_status;
    logic         evt_enable;
    logic         tx_busy;
    logic         tx_packet_wr;
    logic [7:0]   tx_payload_len;
    logic [127:0] tx_buf;
    logic         evt_sent;
    logic         sched_busy;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int stray_evt = 0;

    int           wr_cyc_q[$];
    logic [7:0]   wr_len_q[$];
    logic [127:0] wr_buf_q[$];
    logic         wr_evt_q[$];

    tx_sched #(.HOLDOFF(HOLDOFF), .ACCEPT_TO(ACCEPT_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_len       (resp_len),
        .resp_data      (resp_data),
        .int_status     (int_status),
        .evt_enable     (evt_enable),
        .tx_busy        (tx_busy),
        .tx_packet_wr   (tx_packet_wr),
        .tx_payload_len (tx_payload_len),
        .tx_buf         (tx_buf),
        .evt_sent       (evt_sent),
        .sched_busy     (sched_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every packet the transmitter would see.
    always @(negedge clk) begin
        if (tx_packet_wr) begin
            wr_cyc_q.push_back(cyc);
            wr_len_q.push_back(tx_payload_len);
            wr_buf_q.push_back(tx_buf);
            wr_evt_q.push_back(evt_sent);
        end
        if (evt_sent && !tx_packet_wr) stray_evt++;
    end

    // ---------------- reference model ----------------
    function automatic int m_len(input int l);
        if (l < 1) return 1;
        if (l > 16) return 16;
        return l;
    endfunction

    function automatic logic [127:0] m_resp_buf(input int l, input logic [127:0] d);
        logic [127:0] b;
        b = '0;
        for (int k = 0; k < m_len(l); k++) b[8*k +: 8] = d[8*k +: 8];
        return b;
    endfunction

    function automatic logic [127:0] m_evt_buf(input logic [31:0] s);
        logic [7:0]   bytes [5];
        logic [127:0] b;
        b = '0;
        bytes[0] = 8'h82;
        for (int k = 0; k < 4; k++) bytes[k+1] = 8'(s >> (8*k));
        for (int k = 0; k < 5; k++) b[8*k +: 8] = bytes[k];
        return b;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_log;
        wr_cyc_q.delete();
        wr_len_q.delete();
        wr_buf_q.delete();
        wr_evt_q.delete();
        stray_evt = 0;
    endtask

    task automatic do_reset;
        resp_valid = 1'b0;
        resp_len   = '0;
        resp_data  = '0;
        int_status = '0;
        evt_enable = 1'b0;
        tx_busy    = 1'b0;
        rst        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_log();
    endtask

    task automatic send_resp(input int l, input logic [127:0] d, output int hs);
        int c;
        c  = 0;
        hs = -1;
        resp_len   = 8'(l);
        resp_data  = d;
        resp_valid = 1'b1;
        while (hs < 0 && c < 200) begin
            @(negedge clk);
            if (resp_ready) hs = cyc;
            c++;
        end
        if (hs >= 0) @(posedge clk);
        #1;
        resp_valid = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int limit, output bit ok);
        int c;
        c = 0;
        while (wr_cyc_q.size() < n && c < limit) begin
            @(negedge clk);
            #1;
            c++;
        end
        ok = (wr_cyc_q.size() >= n);
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int c;
        c = 0;
        while ((sched_busy || !resp_ready) && c < limit) begin
            @(negedge clk);
            #1;
            c++;
        end
        ok = !sched_busy && resp_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        resp_valid = 1'b0; resp_len = '0; resp_data = '0;
        int_status = '0; evt_enable = 1'b0; tx_busy = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", resp_ready); end
        n_tests++; if (tx_packet_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", tx_packet_wr); end
        n_tests++; if (evt_sent !== 1'b0) begin n_fail++; $display("FAIL reset_evt_sent: got %b expected 0", evt_sent); end
        n_tests++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", sched_busy); end
        n_tests++; if (tx_payload_len !== 8'h0) begin n_fail++; $display("FAIL reset_len: got %h expected 0", tx_payload_len); end
        n_tests++; if (tx_buf !== 128'h0) begin n_fail++; $display("FAIL reset_buf: got %h expected 0", tx_buf); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        #1;
        n_tests++; if (wr_cyc_q.size() !== 0) begin n_fail++; $display("FAIL reset_release_wr: got %0d writes expected 0", wr_cyc_q.size()); end
    endtask

    task automatic test_single_resp;
        logic [127:0] d;
        int hs;
        do_reset();
        d = rand128();
        d[23:0] = 24'hCEBA81;
        send_resp(3, d, hs);
        n_tests++; if (hs < 0) begin n_fail++; $display("FAIL single_hs: got %0d expected handshake", hs); end
        @(negedge clk); #1;
        n_tests++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b expected 0", resp_ready); end
        n_tests++; if (tx_packet_wr !== 1'b0) begin n_fail++; $display("FAIL single_wr_early: got %b expected 0", tx_packet_wr); end
        @(negedge clk); #1;
        n_tests++; if (tx_packet_wr !== 1'b1) begin n_fail++; $display("FAIL single_wr_latency: got %b expected 1", tx_packet_wr); end
        n_tests++; if (tx_payload_len !== 8'd3) begin n_fail++; $display("FAIL single_len: got %0d expected 3", tx_payload_len); end
        n_tests++; if (tx_buf !== m_resp_buf(3, d)) begin n_fail++; $display("FAIL single_buf: got %h expected %h", tx_buf, m_resp_buf(3, d)); end
        n_tests++; if (evt_sent !== 1'b0) begin n_fail++; $display("FAIL single_evt_sent: got %b expected 0", evt_sent); end
        @(negedge clk); #1;
        n_tests++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_return: got %b expected 1", resp_ready); end
    endtask

    task automatic test_event;
        logic [31:0] st2;
        bit ok;
        int gap;
        do_reset();
        evt_enable = 1'b1;
        int_status = 32'h0000_0005;
        wait_wr(1, 50, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL evt_first: got %0d writes expected 1", wr_cyc_q.size()); end
        if (wr_cyc_q.size() >= 1) begin
            n_tests++; if (wr_len_q[0] !== 8'd5) begin n_fail++; $display("FAIL evt_len: got %0d expected 5", wr_len_q[0]); end
            n_tests++; if (wr_buf_q[0] !== m_evt_buf(32'h5)) begin n_fail++; $display("FAIL evt_buf: got %h expected %h", wr_buf_q[0], m_evt_buf(32'h5)); end
            n_tests++; if (wr_evt_q[0] !== 1'b1) begin n_fail++; $display("FAIL evt_sent_pulse: got %b expected 1", wr_evt_q[0]); end
        end
        repeat (500) @(negedge clk);
        st2 = $urandom;
        if (st2 == 32'h0) st2 = 32'h1;
        int_status = st2;
        wait_wr(2, 1000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL evt_second: got %0d writes expected 2", wr_cyc_q.size()); end
        if (wr_cyc_q.size() >= 2) begin
            gap = wr_cyc_q[1] - wr_cyc_q[0];
            n_tests++; if (gap <= HOLDOFF || gap > HOLDOFF + 8) begin n_fail++; $display("FAIL evt_holdoff_gap: got %0d expected %0d..%0d", gap, HOLDOFF + 1, HOLDOFF + 8); end
            n_tests++; if (wr_buf_q[1] !== m_evt_buf(st2)) begin n_fail++; $display("FAIL evt_snapshot: got %h expected %h", wr_buf_q[1], m_evt_buf(st2)); end
        end
        n_tests++; if (stray_evt !== 0) begin n_fail++; $display("FAIL evt_stray: got %0d expected 0", stray_evt); end
        evt_enable = 1'b0;
        int_status = '0;
    endtask

    task automatic test_tie;
        logic [127:0] d1, d2;
        logic [31:0] st;
        int l1, l2, hs;
        bit ok;
        do_reset();
        tx_busy = 1'b1;
        st = $urandom | 32'h100;
        int_status = st;
        evt_enable = 1'b1;
        l1 = $urandom_range(1, 16); d1 = rand128();
        send_resp(l1, d1, hs);
        n_tests++; if (hs < 0) begin n_fail++; $display("FAIL tie_hs1: got %0d expected handshake", hs); end
        repeat (20) @(negedge clk);
        #1;
        n_tests++; if (wr_cyc_q.size() !== 0) begin n_fail++; $display("FAIL tie_busy_hold: got %0d writes expected 0", wr_cyc_q.size()); end
        n_tests++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL tie_idle_wait: got %b expected 0", sched_busy); end
        tx_busy = 1'b0;
        l2 = $urandom_range(1, 16); d2 = rand128();
        send_resp(l2, d2, hs);
        n_tests++; if (hs < 0) begin n_fail++; $display("FAIL tie_hs2: got %0d expected handshake", hs); end
        wait_wr(3, 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tie_count: got %0d writes expected 3", wr_cyc_q.size()); end
        if (wr_cyc_q.size() >= 3) begin
            n_tests++; if (wr_evt_q[0] !== 1'b0 || wr_buf_q[0] !== m_resp_buf(l1, d1)) begin n_fail++; $display("FAIL tie_first_resp: got evt=%b %h expected evt=0 %h", wr_evt_q[0], wr_buf_q[0], m_resp_buf(l1, d1)); end
            n_tests++; if (wr_evt_q[1] !== 1'b1 || wr_buf_q[1] !== m_evt_buf(st)) begin n_fail++; $display("FAIL tie_second_evt: got evt=%b %h expected evt=1 %h", wr_evt_q[1], wr_buf_q[1], m_evt_buf(st)); end
            n_tests++; if (wr_evt_q[2] !== 1'b0 || wr_buf_q[2] !== m_resp_buf(l2, d2)) begin n_fail++; $display("FAIL tie_third_resp: got evt=%b %h expected evt=0 %h", wr_evt_q[2], wr_buf_q[2], m_resp_buf(l2, d2)); end
        end
        evt_enable = 1'b0;
        int_status = '0;
    endtask

    task automatic test_accept_timeout;
        logic [127:0] d1, d2;
        int l1, l2, hs1, hs2;
        bit ok;
        do_reset();
        l1 = $urandom_range(1, 16); d1 = rand128();
        l2 = $urandom_range(1, 16); d2 = rand128();
        send_resp(l1, d1, hs1);
        send_resp(l2, d2, hs2);
        wait_wr(2, 60, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL acc_count: got %0d writes expected 2", wr_cyc_q.size()); end
        if (wr_cyc_q.size() >= 2) begin
            n_tests++; if (hs2 !== wr_cyc_q[0] + 1) begin n_fail++; $display("FAIL acc_b2b_accept: got cycle %0d expected %0d", hs2, wr_cyc_q[0] + 1); end
            n_tests++; if (wr_cyc_q[1] - wr_cyc_q[0] !== ACCEPT_TO + 2) begin n_fail++; $display("FAIL acc_timeout_gap: got %0d expected %0d", wr_cyc_q[1] - wr_cyc_q[0], ACCEPT_TO + 2); end
            n_tests++; if (wr_buf_q[1] !== m_resp_buf(l2, d2)) begin n_fail++; $display("FAIL acc_next_buf: got %h expected %h", wr_buf_q[1], m_resp_buf(l2, d2)); end
        end
        wait_idle(20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL acc_return_idle: got busy=%b expected 0", sched_busy); end
    endtask

    task automatic test_back_to_back;
        int hs, l, seen, guard, k, n;
        logic [127:0] d;
        bit ok;
        int           exp_len_q[$];
        logic [127:0] exp_buf_q[$];
        do_reset();
        fork
            begin
                for (int i = 0; i < NB; i++) begin
                    l = $urandom_range(0, 24);
                    d = rand128();
                    send_resp(l, d, hs);
                    n_tests++;
                    if (hs < 0) begin
                        n_fail++; $display("FAIL b2b_hs: got %0d expected handshake for item %0d", hs, i);
                    end else begin
                        exp_len_q.push_back(m_len(l));
                        exp_buf_q.push_back(m_resp_buf(l, d));
                    end
                end
            end
            begin
                seen = 0;
                guard = 0;
                while (seen < NB && guard < 3000) begin
                    @(negedge clk);
                    #1;
                    guard++;
                    if (wr_cyc_q.size() > seen) begin
                        seen = wr_cyc_q.size();
                        if ($urandom_range(0, 1) == 1) begin
                            @(posedge clk);
                            #1;
                            tx_busy = 1'b1;
                            k = $urandom_range(1, 6);
                            repeat (k) @(posedge clk);
                            #1;
                            tx_busy = 1'b0;
                        end
                    end
                end
            end
        join
        wait_idle(50, ok);
        n_tests++; if (wr_cyc_q.size() !== exp_buf_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", wr_cyc_q.size(), exp_buf_q.size()); end
        n = (wr_cyc_q.size() < exp_buf_q.size()) ? wr_cyc_q.size() : exp_buf_q.size();
        for (int i = 0; i < n; i++) begin
            n_tests++; if (wr_len_q[i] !== 8'(exp_len_q[i])) begin n_fail++; $display("FAIL b2b_len[%0d]: got %0d expected %0d", i, wr_len_q[i], exp_len_q[i]); end
            n_tests++; if (wr_buf_q[i] !== exp_buf_q[i]) begin n_fail++; $display("FAIL b2b_buf[%0d]: got %h expected %h", i, wr_buf_q[i], exp_buf_q[i]); end
        end
    endtask

    task automatic test_len_clamp_mask;
        logic [127:0] d0, d1;
        int hs;
        bit ok;
        do_reset();
        int_status = 32'hFFFF_FFFF;
        evt_enable = 1'b0;
        d0 = rand128(); d1 = rand128();
        send_resp(0, d0, hs);
        wait_wr(1, 20, ok);
        send_resp(20, d1, hs);
        wait_wr(2, 20, ok);
        repeat (60) @(negedge clk);
        #1;
        n_tests++; if (wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL mask_no_event: got %0d writes expected 2", wr_cyc_q.size()); end
        if (wr_cyc_q.size() >= 2) begin
            n_tests++; if (wr_len_q[0] !== 8'd1) begin n_fail++; $display("FAIL clamp_zero: got %0d expected 1", wr_len_q[0]); end
            n_tests++; if (wr_buf_q[0] !== m_resp_buf(0, d0)) begin n_fail++; $display("FAIL clamp_zero_buf: got %h expected %h", wr_buf_q[0], m_resp_buf(0, d0)); end
            n_tests++; if (wr_len_q[1] !== 8'd16) begin n_fail++; $display("FAIL clamp_twenty: got %0d expected 16", wr_len_q[1]); end
            n_tests++; if (wr_evt_q[0] !== 1'b0 || wr_evt_q[1] !== 1'b0) begin n_fail++; $display("FAIL mask_evt_flag: got %b%b expected 00", wr_evt_q[0], wr_evt_q[1]); end
        end
        evt_enable = 1'b1;
        wait_wr(3, 30, ok);
        n_tests++; if (!ok || wr_buf_q[wr_buf_q.size()-1] !== m_evt_buf(32'hFFFF_FFFF)) begin n_fail++; $display("FAIL unmask_event: got %0d writes, last %h expected %h", wr_cyc_q.size(), wr_buf_q[wr_buf_q.size()-1], m_evt_buf(32'hFFFF_FFFF)); end
        evt_enable = 1'b0;
        int_status = '0;
    endtask

    task automatic test_reset_mid_packet;
        int hs, n0;
        bit ok;
        do_reset();
        send_resp($urandom_range(1, 16), rand128(), hs);
        wait_wr(1, 20, ok);
        tx_busy = 1'b1;
        send_resp($urandom_range(1, 16), rand128(), hs);
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (sched_busy !== 1'b1) begin n_fail++; $display("FAIL mid_wait_done: got %b expected 1", sched_busy); end
        n_tests++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL mid_buffered: got %b expected 0", resp_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", resp_ready); end
        n_tests++; if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", sched_busy); end
        n_tests++; if (tx_packet_wr !== 1'b0 || evt_sent !== 1'b0) begin n_fail++; $display("FAIL mid_rst_strobes: got wr=%b evt=%b expected 0 0", tx_packet_wr, evt_sent); end
        n_tests++; if (tx_payload_len !== 8'h0 || tx_buf !== 128'h0) begin n_fail++; $display("FAIL mid_rst_outputs: got len=%h buf=%h expected 0", tx_payload_len, tx_buf); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tx_busy = 1'b0;
        n0 = wr_cyc_q.size();
        repeat (30) @(negedge clk);
        #1;
        n_tests++; if (wr_cyc_q.size() !== n0) begin n_fail++; $display("FAIL mid_no_wr_after: got %0d writes expected %0d", wr_cyc_q.size(), n0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_resp();
        test_event();
        test_tie();
        test_accept_timeout();
        test_back_to_back();
        test_len_clamp_mask();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
